// File: rtl/vram_b_arbiter.sv
// Two-requester round-robin arbiter for VRAM port B with bounded burst lock.
// Registered command outputs; read responses are routed back to their issuer via a latency pipe.
module vram_b_arbiter #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    input  logic              REQ0_WE,
    input  logic              REQ0_LOCK,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic              REQ1_WE,
    input  logic              REQ1_LOCK,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              RSP0_VALID,
    output logic              RSP1_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [ADDR_W-1:0] ADDR_B,
    output logic [DATA_W-1:0] DATA_B,
    output logic              WE_B,
    input  logic [DATA_W-1:0] Q_B
);

    localparam int         DEPTH     = RD_LAT + 1;
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t      owner_reg, owner_next;
    logic        last_reg, last_next;
    logic [7:0]  burst_cnt_reg, burst_cnt_next;

    logic [1:0]  valid_vec;
    logic [1:0]  lock_vec;
    logic [1:0]  we_vec;
    logic        owner_id;
    logic        owner_live;
    logic        preempt;
    logic [1:0]  gnt_vec;
    logic        beat;
    logic        gnt_id;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign valid_vec = {REQ1_VALID, REQ0_VALID};
    assign lock_vec  = {REQ1_LOCK, REQ0_LOCK};
    assign we_vec    = {REQ1_WE, REQ0_WE};

    // Grant decision: purely from request inputs and arbiter state, never from Q_B.
    always_comb begin
        owner_id   = (owner_reg == OWN_R1);
        owner_live = (owner_reg != OWN_NONE) && valid_vec[owner_id];
        preempt    = owner_live && valid_vec[~owner_id] && (burst_cnt_reg == BURST_MAX);
        gnt_vec    = 2'b00;
        if (!RST_N) begin
            gnt_vec = 2'b00;
        end else if (owner_live) begin
            gnt_vec[preempt ? ~owner_id : owner_id] = 1'b1;
        end else if (&valid_vec) begin
            gnt_vec[~last_reg] = 1'b1;
        end else begin
            gnt_vec = valid_vec;
        end
    end

    assign beat       = |gnt_vec;
    assign gnt_id     = gnt_vec[1];
    assign REQ0_READY = gnt_vec[0];
    assign REQ1_READY = gnt_vec[1];

    assign sel_addr = gnt_id ? REQ1_ADDR : REQ0_ADDR;
    assign sel_data = gnt_id ? REQ1_DATA : REQ0_DATA;

    // An owner that stops requesting loses ownership even when nobody else is granted.
    always_comb begin
        owner_next     = owner_live ? owner_reg : OWN_NONE;
        last_next      = last_reg;
        burst_cnt_next = burst_cnt_reg;
        if (beat) begin
            last_next = gnt_id;
            if (lock_vec[gnt_id]) begin
                owner_next = gnt_id ? OWN_R1 : OWN_R0;
                if (owner_live && !preempt) begin
                    burst_cnt_next = (burst_cnt_reg >= BURST_MAX) ? BURST_MAX
                                                                  : burst_cnt_reg + 8'd1;
                end else begin
                    burst_cnt_next = 8'd1;
                end
            end else begin
                owner_next     = OWN_NONE;
                burst_cnt_next = 8'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_reg     <= OWN_NONE;
            last_reg      <= 1'b1;
            burst_cnt_reg <= 8'd0;
        end else begin
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // Command register toward the VRAM; address/data hold when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ADDR_B <= '0;
            DATA_B <= '0;
            WE_B   <= 1'b0;
        end else if (beat) begin
            ADDR_B <= sel_addr;
            DATA_B <= sel_data;
            WE_B   <= we_vec[gnt_id];
        end else begin
            WE_B   <= 1'b0;
        end
    end

    // Read-tracking pipe: stage DEPTH-1 lines up with Q_B for the read it describes.
    logic rd_valid_reg  [DEPTH];
    logic rd_id_reg     [DEPTH];
    logic rd_valid_next [DEPTH];
    logic rd_id_next    [DEPTH];

    assign rd_valid_next[0] = beat && !we_vec[gnt_id];
    assign rd_id_next[0]    = gnt_id;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_rd_pipe
            assign rd_valid_next[gi] = rd_valid_reg[gi-1];
            assign rd_id_next[gi]    = rd_id_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_valid_reg[i] <= 1'b0;
                rd_id_reg[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_valid_reg[i] <= rd_valid_next[i];
                rd_id_reg[i]    <= rd_id_next[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RSP_DATA   <= '0;
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
        end else begin
            RSP0_VALID <= rd_valid_reg[DEPTH-1] && !rd_id_reg[DEPTH-1];
            RSP1_VALID <= rd_valid_reg[DEPTH-1] &&  rd_id_reg[DEPTH-1];
            if (rd_valid_reg[DEPTH-1]) begin
                RSP_DATA <= Q_B;
            end
        end
    end

endmodule

// File: tb/tb_vram_b_arbiter.sv
// Randomized and directed bench for vram_b_arbiter with a behavioural VRAM,
// a rule-level arbitration model and a response scoreboard.
module tb_vram_b_arbiter;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 16;

    logic              CLK;
    logic              RST_N;
    logic              REQ0_VALID, REQ0_WE, REQ0_LOCK, REQ0_READY;
    logic [ADDR_W-1:0] REQ0_ADDR;
    logic [DATA_W-1:0] REQ0_DATA;
    logic              REQ1_VALID, REQ1_WE, REQ1_LOCK, REQ1_READY;
    logic [ADDR_W-1:0] REQ1_ADDR;
    logic [DATA_W-1:0] REQ1_DATA;
    logic              RSP0_VALID, RSP1_VALID;
    logic [DATA_W-1:0] RSP_DATA;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] DATA_B;
    logic              WE_B;
    logic [DATA_W-1:0] Q_B;

    vram_b_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_LOCK(REQ0_LOCK),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_LOCK(REQ1_LOCK),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID), .RSP_DATA(RSP_DATA),
        .ADDR_B(ADDR_B), .DATA_B(DATA_B), .WE_B(WE_B), .Q_B(Q_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural VRAM port B: write-first, one cycle read latency, cleared by reset.
    logic [DATA_W-1:0] vram_mem [4096];
    always @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 4096; i++) vram_mem[i] <= '0;
            Q_B <= '0;
        end else if (WE_B) begin
            vram_mem[ADDR_B[11:0]] <= DATA_B;
            Q_B <= DATA_B;
        end else begin
            Q_B <= vram_mem[ADDR_B[11:0]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model state: rule-level view of the arbiter.
    int               m_owner = -1;
    int               m_last  = 1;
    int               m_cnt   = 0;
    logic             exp_we   = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [DATA_W-1:0] shadow [int];

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;
    rsp_t rsp_q [$];

    function automatic int pick(input logic v0, input logic v1);
        logic [1:0] v;
        v = {v1, v0};
        if (m_owner >= 0 && v[m_owner]) begin
            if (v[1 - m_owner] && m_cnt == MAX_BURST) return 1 - m_owner;
            return m_owner;
        end
        if (v0 && v1) return 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Model: predicts grant each cycle and pushes expected command / response.
    initial forever begin
        int                g;
        logic              wk, lk;
        logic [ADDR_W-1:0] ak;
        logic [DATA_W-1:0] dk, rd;
        @(negedge CLK);
        if (!RST_N) begin
            m_owner = -1; m_last = 1; m_cnt = 0;
            exp_we = 1'b0; exp_addr = '0; exp_data = '0;
            shadow.delete();
            check("ready_in_reset", {REQ1_READY, REQ0_READY}, 64'd0);
        end else begin
            g = pick(REQ0_VALID, REQ1_VALID);
            check("ready", {REQ1_READY, REQ0_READY}, {62'd0, g == 1, g == 0});
            if (g >= 0) begin
                wk = (g == 0) ? REQ0_WE   : REQ1_WE;
                lk = (g == 0) ? REQ0_LOCK : REQ1_LOCK;
                ak = (g == 0) ? REQ0_ADDR : REQ1_ADDR;
                dk = (g == 0) ? REQ0_DATA : REQ1_DATA;
                $display("[TB] cyc %0d beat R%0d we=%0b lock=%0b addr=%05h data=%02h",
                         cyc, g, wk, lk, ak, dk);
                if (lk) begin
                    m_cnt   = (m_owner == g) ? ((m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1) : 1;
                    m_owner = g;
                end else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
                m_last   = g;
                exp_we   = wk;
                exp_addr = ak;
                exp_data = dk;
                if (wk) begin
                    shadow[int'(ak)] = dk;
                end else begin
                    rd = shadow.exists(int'(ak)) ? shadow[int'(ak)] : '0;
                    rsp_q.push_back('{due: cyc + 2 + RD_LAT, id: g, data: rd});
                end
            end else begin
                if (m_owner >= 0) m_owner = -1;
                exp_we = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against model expectations away from the clock edge.
    initial forever begin
        rsp_t e;
        @(posedge CLK);
        #3;
        if (!RST_N) begin
            check("reset_outputs", {ADDR_B, DATA_B, WE_B, RSP_DATA, RSP0_VALID, RSP1_VALID}, 64'd0);
            rsp_q.delete();
        end else begin
            check("command", {WE_B, ADDR_B, DATA_B}, {exp_we, exp_addr, exp_data});
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                e = rsp_q.pop_front();
                check("response", {RSP1_VALID, RSP0_VALID, RSP_DATA},
                      {e.id == 1, e.id == 0, e.data});
                $display("[TB] cyc %0d resp R%0d data=%02h", cyc, e.id, RSP_DATA);
            end else begin
                check("no_response", {RSP1_VALID, RSP0_VALID}, 64'd0);
            end
        end
    end

    task automatic issue(input int k, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         output int waited);
        logic acc;
        if (k == 0) begin
            REQ0_VALID = 1'b1; REQ0_WE = we; REQ0_LOCK = lock; REQ0_ADDR = addr; REQ0_DATA = data;
        end else begin
            REQ1_VALID = 1'b1; REQ1_WE = we; REQ1_LOCK = lock; REQ1_ADDR = addr; REQ1_DATA = data;
        end
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge CLK);
            acc = (k == 0) ? (REQ0_VALID && REQ0_READY) : (REQ1_VALID && REQ1_READY);
            waited++;
            @(posedge CLK);
            #1;
        end
        if (!acc) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drop(input int k);
        if (k == 0) begin REQ0_VALID = 1'b0; REQ0_LOCK = 1'b0; end
        else        begin REQ1_VALID = 1'b0; REQ1_LOCK = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int w;
    int w0;
    int w1;
    int r0_beats;

    initial begin
        REQ0_VALID = 0; REQ0_WE = 0; REQ0_LOCK = 0; REQ0_ADDR = '0; REQ0_DATA = '0;
        REQ1_VALID = 0; REQ1_WE = 0; REQ1_LOCK = 0; REQ1_ADDR = '0; REQ1_DATA = '0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        idle(20);

        // Single write then read back of the same byte.
        issue(0, 1'b1, 1'b0, 18'h12345, 8'hA5, w);
        issue(0, 1'b0, 1'b0, 18'h12345, 8'h00, w);
        drop(0);
        idle(6);

        // Seed addresses 0..15 with known data.
        for (int i = 0; i < 16; i++) issue(1, 1'b1, 1'b0, 18'(i), 8'(i * 17 + 3), w);
        drop(1);
        idle(2);

        // Round-robin with continuous unlocked reads from both sides.
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 1'b0, 1'b0, 18'(i), 8'h00, w0);
                drop(0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(1, 1'b0, 1'b0, 18'(i + 8), 8'h00, w1);
                    if (i == 0) check("rr_first_r1_wait", 64'(w1), 64'd2);
                end
                drop(1);
            end
        join
        idle(5);

        // Burst lock with starvation bound.
        r0_beats = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    issue(0, 1'(i % 3 == 0), 1'b1, 18'(i % 16), 8'(i * 7), w0);
                    r0_beats++;
                end
                drop(0);
            end
            begin
                idle(3);
                issue(1, 1'b0, 1'b0, 18'h5, 8'h00, w1);
                check("burst_bound", 64'(r0_beats), 64'(MAX_BURST));
                drop(1);
            end
        join
        idle(5);

        // Owner drops VALID while the other side is waiting.
        issue(1, 1'b0, 1'b1, 18'h7, 8'h00, w1);
        drop(1);
        issue(0, 1'b0, 1'b0, 18'h9, 8'h00, w0);
        check("owner_drop_same_cycle", 64'(w0), 64'd1);
        drop(0);
        idle(5);

        // Reset right after three back-to-back reads.
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 1'b0, 18'(i + 1), 8'h00, w1);
        drop(1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        idle(8);

        // Randomized traffic from both requesters.
        fork
            begin
                int n;
                for (int i = 0; i < 150; i++) begin
                    n = int'($urandom_range(0, 2));
                    if (n > 0) begin drop(0); idle(n); end
                    issue(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          18'($urandom_range(0, 63)), 8'($urandom), w0);
                end
                drop(0);
            end
            begin
                int n;
                for (int i = 0; i < 150; i++) begin
                    n = int'($urandom_range(0, 2));
                    if (n > 0) begin drop(1); idle(n); end
                    issue(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          18'($urandom_range(0, 63)), 8'($urandom), w1);
                end
                drop(1);
            end
        join

        idle(8);
        check("drain", 64'(rsp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_b_arbiter.md
# vram_b_arbiter

Shares the write/read port B of the dual-clock framebuffer VRAM between two requesters in the system `CLK` domain: R0 (rasterizer/fill engine) and R1 (host/register bus). It performs round-robin arbitration with a bounded burst lock and drives `ADDR_B`/`DATA_B`/`WE_B` from registers. It tracks outstanding reads through the BRAM latency and returns each read word to the requester that issued it. Port A (scanout, `clk25`) is untouched.

## Interface
- `ADDR_W`, 18, VRAM byte-address width (matches port B).
- `DATA_W`, 8, VRAM data width.
- `RD_LAT`, 1, port-B read latency in cycles from the address register to `Q_B` valid (1 or 2).
- `MAX_BURST`, 16, maximum consecutive grants to one locked requester while the other waits (2..255).

Ports:
- `CLK`  in  1  system clock; everything is synchronous to its rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `REQ0_VALID`, `REQ1_VALID`  in  1  request present.
- `REQ0_WE`, `REQ1_WE`  in  1  1 = write, 0 = read.
- `REQ0_LOCK`, `REQ1_LOCK`  in  1  keep the grant for the next beat (span burst).
- `REQ0_ADDR`, `REQ1_ADDR`  in  ADDR_W  byte address.
- `REQ0_DATA`, `REQ1_DATA`  in  DATA_W  write data.
- `REQ0_READY`, `REQ1_READY`  out  1  grant; combinational from VALID/LOCK and internal state.
- `RSP0_VALID`, `RSP1_VALID`  out  1  read data valid, single-cycle pulse.
- `RSP_DATA`  out  DATA_W  registered read data; shared, qualified by `RSPx_VALID`.
- `ADDR_B`  out  ADDR_W  to the VRAM.
- `DATA_B`  out  DATA_W  to the VRAM.
- `WE_B`  out  1  to the VRAM.
- `Q_B`  in  DATA_W  from the VRAM.

## Operation
- A handshake (beat) happens in a cycle when `REQx_VALID & REQx_READY` is true.
- At most one beat per cycle. A requester keeps VALID and its fields stable until READY.
- State:
  - `last`: the last granted requester; resets to 1, so R0 wins the first tie.
  - `owner`: none/R0/R1.
  - `burst_cnt`: 8 bits.
- Grant rules, evaluated each cycle:
  - If `owner` = Rk and `REQk_VALID`, then Rk is granted. Exception: the other requester is valid and `burst_cnt` = MAX_BURST; then the other requester is granted and `owner` clears.
  - Otherwise, with exactly one requester valid, that requester is granted.
  - Otherwise, with both valid, the requester ≠ `last` is granted.
  - If the owner drops VALID, `owner` clears immediately and the normal rules apply in the same cycle.
- After a beat by Rk:
  - `last` ← k.
  - If `REQk_LOCK` = 1, then `owner` ← Rk and `burst_cnt` ← `burst_cnt`+1 (or 1 if the owner changed). Otherwise `owner` ← none and `burst_cnt` ← 0.
  - `burst_cnt` saturates at MAX_BURST.
- Command register, updated on a beat:
  - `ADDR_B` ← ADDR and `DATA_B` ← DATA of the granted requester.
  - `WE_B` ← WE.
- With no beat, `WE_B` ← 0 while `ADDR_B`/`DATA_B` hold their values.
- Read tracking: a shift register of depth RD_LAT+1 carries {valid, id}.
  - A read beat enters {1, k}. A write beat or no beat enters {0, x}.
  - When an entry exits, `RSP_DATA` ← `Q_B` and `RSPk_VALID` ← 1 for one cycle.
  - Reads and writes interleave freely. Responses return in issue order.
  - There is no backpressure on responses: requesters must always accept them.
- A write produces no response.
- A read of an address written in the previous beat returns the new data: the port is write-first. A mix of the two orders is not required.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `ADDR_B`=0, `DATA_B`=0, `WE_B`=0, `RSP_DATA`=0, `RSP0_VALID`=`RSP1_VALID`=0.
  - `owner`=none, `last`=1, `burst_cnt`=0, pipeline cleared.
- `REQx_READY` is low while `RST_N` is low.
- Reset mid-operation drops in-flight reads: no `RSPx_VALID` appears for them after release.
- Beat in cycle T:
  - `ADDR_B`/`WE_B` are valid in T+1.
  - For a read, `RSPk_VALID`/`RSP_DATA` are valid in T+2+RD_LAT (T+3 at default).
- Throughput is one beat per cycle sustained. Both requesters valid with no lock gives strict alternation R0,R1,R0,…
- The READY path must not depend on `Q_B`.

## Test plan
- Reset then idle: after reset, check every output at its reset value. With VALIDs low for 20 cycles, `WE_B` must stay 0.
- Single write then read: R0 writes 0xA5 to 0x12345 in T. Check `ADDR_B`=0x12345, `WE_B`=1, `DATA_B`=0xA5 at T+1. R0 then reads 0x12345 in T+1. Check `RSP0_VALID`=1 with `RSP_DATA`=0xA5 at T+4, and `RSP1_VALID` stays 0.
- Round-robin: both requesters read continuously with no lock for 8 cycles. Grants must be R0,R1,R0,R1,… with responses tagged in the same order and the correct data for each.
- Burst lock and starvation bound: R0 holds LOCK and VALID for 40 beats while R1 becomes valid at beat 3. R0 receives 16 consecutive grants (MAX_BURST), then R1 receives exactly one grant, then R0 resumes.
- Owner drop: R1 is locked and drops VALID while R0 is valid. R0 is granted in that same cycle.
- Reset mid-read: R1 issues 3 back-to-back reads, then `RST_N` is pulsed low for one cycle right after the last beat. No `RSP1_VALID` occurs, and all outputs are at their reset values during reset.
